// File: rtl/branch_predict_ctr.sv
// branch_predict_ctr: resolves conditional branches from ALU flags and keeps
// a PC-indexed table of saturating counters that predicts branch direction.
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   pred_pc         - fetch PC looked up in the table
//   pred_taken      - predicted direction for pred_pc (combinational)
//   BE, BS          - branch enable and funct3 select from EX
//   ZERO, SLT, SLTU - ALU compare flags
//   res_pc          - PC of the resolving branch (table index to train)
//   res_pred        - prediction that was used for the resolving branch
//   PCS             - actual branch outcome (combinational)
//   mispredict      - resolved direction differs from res_pred
// Optional feature macro BP_STATS_EN adds stat_branches / stat_mispredicts.
module branch_predict_ctr #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            BE,
  input  logic [2:0]      BS,
  input  logic            ZERO,
  input  logic            SLT,
  input  logic            SLTU,
  input  logic [PC_W-1:0] res_pc,
  input  logic            res_pred,
  output logic            PCS,
  output logic            mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Weakly not-taken: 2^(CTR_W-1)-1, which is 0 for a 1-bit counter.
  localparam logic [CTR_W-1:0] CTR_RST =
    CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [CTR_W-1:0] r_ctr [ENTRIES];

  logic [IDX_W-1:0] w_pidx;
  logic [IDX_W-1:0] w_ridx;
  logic             w_cond;
  logic             w_rsvd;
  logic             w_upd;
  logic             w_unused;

  assign w_pidx = pred_pc[2 +: IDX_W];
  assign w_ridx = res_pc[2 +: IDX_W];

  // Only the index bits of the PCs matter.
  assign w_unused = ^{pred_pc, res_pc};

  assign pred_taken = r_ctr[w_pidx][CTR_W-1];

  always_comb begin
    w_cond = 1'b0;
    w_rsvd = 1'b0;
    unique case (BS)
      3'b000: w_cond = ZERO;
      3'b001: w_cond = !ZERO;
      3'b100: w_cond = SLT;
      3'b101: w_cond = !SLT;
      3'b110: w_cond = SLTU;
      3'b111: w_cond = !SLTU;
      3'b010,
      3'b011: w_rsvd = 1'b1;
    endcase
  end

  assign PCS        = BE && w_cond;
  assign mispredict = BE && (PCS != res_pred);
  assign w_upd      = BE && !w_rsvd;

  // Saturation is tested before the add/sub so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        r_ctr[i] <= CTR_RST;
    end else if (w_upd) begin
      if (PCS) begin
        if (r_ctr[w_ridx] != CTR_MAX)
          r_ctr[w_ridx] <= r_ctr[w_ridx] + 1'b1;
      end else begin
        if (r_ctr[w_ridx] != '0)
          r_ctr[w_ridx] <= r_ctr[w_ridx] - 1'b1;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (w_upd) begin
      if (r_stat_br != '1)
        r_stat_br <= r_stat_br + 32'd1;
      if (mispredict && (r_stat_mp != '1))
        r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`endif

endmodule

// File: tb/tb_branch_predict_ctr.sv
// tb_branch_predict_ctr: directed vectors for branch_predict_ctr
// with hand-computed expectations.
module tb_branch_predict_ctr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        BE;
  logic [2:0]  BS;
  logic        ZERO, SLT, SLTU;
  logic [31:0] res_pc;
  logic        res_pred;
  logic        PCS;
  logic        mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_ctr dut (
    .clk        (clk),
    .rst        (rst),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .BE         (BE),
    .BS         (BS),
    .ZERO       (ZERO),
    .SLT        (SLT),
    .SLTU       (SLTU),
    .res_pc     (res_pc),
    .res_pred   (res_pred),
    .PCS        (PCS),
    .mispredict (mispredict)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    BE = 1'b0; BS = 3'b000;
    ZERO = 1'b0; SLT = 1'b0; SLTU = 1'b0;
    res_pc = '0; res_pred = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc,
                      input logic exp,
                      input string tag);
    pred_pc = pc;
    @(negedge clk);
    chk(tag, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  // One BEQ resolve at pc, taken when tk=1.
  task automatic res(input logic [31:0] pc, input logic tk);
    BE = 1'b1; BS = 3'b000; ZERO = tk;
    res_pc = pc; res_pred = 1'b0;
    cyc();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Branch outcome table from the ISA funct3 encoding.
  function automatic logic exp_pcs(input logic [2:0] bs,
                                   input logic z,
                                   input logic lt,
                                   input logic ltu);
    case (bs)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    pred_pc = '0;
    idle();
    do_reset();

    // Reset state: weakly not-taken everywhere.
    look(32'h40, 1'b0, "rst_p40");
    look(32'h7C, 1'b0, "rst_p7c");

    // First resolve: taken, predicted not-taken.
    BE = 1'b1; BS = 3'b000; ZERO = 1'b1;
    res_pc = 32'h40; res_pred = 1'b0;
    @(negedge clk);
    chk("first_pcs", {31'd0, PCS}, 32'd1);
    chk("first_mis", {31'd0, mispredict}, 32'd1);
    cyc();
    idle();
    look(32'h40, 1'b1, "first_next"); // ctr=2

    // Saturate high then walk down.
    repeat (4) res(32'h40, 1'b1);      // ctr=3
    look(32'h40, 1'b1, "sat3");
    res(32'h40, 1'b0);                 // ctr=2
    look(32'h40, 1'b1, "dn2");
    res(32'h40, 1'b0);                 // ctr=1
    look(32'h40, 1'b0, "dn1");
    res(32'h40, 1'b0);                 // ctr=0
    look(32'h40, 1'b0, "dn0");
    res(32'h40, 1'b0);                 // stays 0
    res(32'h40, 1'b1);                 // ctr=1
    look(32'h40, 1'b0, "floor_up1");
    res(32'h40, 1'b1);                 // ctr=2
    look(32'h40, 1'b1, "floor_up2");

    // Aliasing.
    res(32'h40, 1'b1);                 // ctr=3
    look(32'h80, 1'b1, "alias_p80");
    look(32'h44, 1'b0, "alias_p44");

    // Decode sweep on an otherwise unused index.
    for (int bs = 0; bs < 8; bs++) begin
      for (int f = 0; f < 8; f++) begin
        BE = 1'b1; BS = 3'(bs);
        ZERO = f[0]; SLT = f[1]; SLTU = f[2];
        res_pc = 32'h7C; res_pred = 1'b0;
        @(negedge clk);
        chk($sformatf("dec_bs%0d_f%0d", bs, f), {31'd0, PCS},
            {31'd0, exp_pcs(3'(bs), f[0], f[1], f[2])});
        cyc();
      end
    end
    idle();

    // Reserved selects: no outcome, no training.
    do_reset();
    BE = 1'b1; BS = 3'b010; ZERO = 1'b1;
    SLT = 1'b1; SLTU = 1'b1;
    res_pc = 32'h40; res_pred = 1'b1;
    @(negedge clk);
    chk("rsv010_pcs", {31'd0, PCS}, 32'd0);
    chk("rsv010_mis", {31'd0, mispredict}, 32'd1);
    cyc();
    BS = 3'b011; res_pred = 1'b0;
    @(negedge clk);
    chk("rsv011_pcs", {31'd0, PCS}, 32'd0);
    chk("rsv011_mis", {31'd0, mispredict}, 32'd0);
    cyc();
    cyc();
    idle();
    res(32'h40, 1'b1);                 // 1->2 if untouched
    look(32'h40, 1'b1, "rsv_no_upd");

    // BE=0 ignores flags.
    BE = 1'b0; BS = 3'b000; ZERO = 1'b1; res_pred = 1'b1;
    @(negedge clk);
    chk("be0_pcs", {31'd0, PCS}, 32'd0);
    chk("be0_mis", {31'd0, mispredict}, 32'd0);
    cyc();
    idle();

    // Same-cycle lookup/update: no bypass.
    do_reset();
    pred_pc = 32'h40;
    BE = 1'b1; BS = 3'b000; ZERO = 1'b1;
    res_pc = 32'h40; res_pred = 1'b0;
    @(negedge clk);
    chk("same_cyc", {31'd0, pred_taken}, 32'd0);
    cyc();
    idle();
    look(32'h40, 1'b1, "same_next");

    // Reset beats a coincident update.
    do_reset();
    rst = 1'b1;
    BE = 1'b1; BS = 3'b000; ZERO = 1'b1;
    res_pc = 32'h40; res_pred = 1'b0;
    @(negedge clk);
    chk("rst_be_pcs", {31'd0, PCS}, 32'd1);
    cyc();
    rst = 1'b0;
    idle();
    look(32'h40, 1'b0, "rst_win");
    res(32'h40, 1'b1);                 // ctr was 1 -> 2
    look(32'h40, 1'b1, "rst_win_ctr1");

`ifdef BP_STATS_EN
    do_reset();
    chk("st_rst_br", stat_branches, 32'd0);
    chk("st_rst_mp", stat_mispredicts, 32'd0);
    for (int k = 0; k < 5; k++) begin
      BE = 1'b1; BS = 3'b000; ZERO = 1'b1;
      res_pc = 32'h48;
      res_pred = (k < 2) ? 1'b0 : 1'b1;
      cyc();
    end
    BS = 3'b011;
    cyc();
    idle();
    @(negedge clk);
    chk("st_br", stat_branches, 32'd5);
    chk("st_mp", stat_mispredicts, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule

// File: doc/branch_predict_ctr.md
# branch_predict_ctr

Parametrised successor to the branch-decision logic. It resolves conditional branches from the ALU flags (BE/BS/ZERO/SLT/SLTU → PCS) and adds a direction predictor: a table of saturating counters indexed by PC, read combinationally at fetch and trained at branch resolution. It reports a mispredict flag that the pipeline uses to flush fetch/decode. It sits between the EX-stage ALU flags and the PC-select mux.

## Interface
- ENTRIES, 16: predictor table depth; power of 2, ≥2.
- PC_W, 32: PC width.
- CTR_W, 2: saturating counter width; ≥1.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- pred_pc  in  PC_W  fetch-stage PC for lookup.
- pred_taken  out  1  predicted direction for pred_pc (combinational).
- BE  in  1  branch enable: EX holds a conditional branch this cycle.
- BS  in  3  branch select (RISC-V funct3).
- ZERO, SLT, SLTU  in  1 each  ALU flags for the branch compare.
- res_pc  in  PC_W  PC of the resolving branch.
- res_pred  in  1  prediction originally used for that branch.
- PCS  out  1  actual taken (combinational).
- mispredict  out  1  BE && (PCS != res_pred) (combinational).

## Operation
- Index: idx(pc) = pc[2 +: log2(ENTRIES)]; PCs aliasing to one index share a counter.
- Decode of PCS (only when BE=1, else PCS=0):
  - 000 BEQ: ZERO; 001 BNE: !ZERO; 100 BLT: SLT; 101 BGE: !SLT; 110 BLTU: SLTU; 111 BGEU: !SLTU.
  - 010, 011 reserved: PCS=0, no table update, mispredict = res_pred.
- pred_taken = MSB of ctr[idx(pred_pc)].
- Update, at the clock edge when BE=1 and BS not reserved and rst=0:
  - PCS=1: ctr[idx(res_pc)] += 1, saturating at 2^CTR_W−1.
  - PCS=0: ctr[idx(res_pc)] −= 1, saturating at 0.
- Counter arithmetic is CTR_W bits with no wrap; saturation checks precede the add/sub.

## Timing
- Reset: every counter set to 2^(CTR_W−1)−1 (weakly not-taken; 01 for CTR_W=2). CTR_W=1 resets to 0. After reset, pred_taken=0 for every PC.
- PCS, mispredict, and pred_taken have zero latency (combinational from inputs and current table).
- A table update is visible to lookup from the cycle after the edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value; no bypass.
- rst asserted together with BE: reset wins and the update is discarded. PCS/mispredict still reflect the inputs combinationally.
- Reset mid-operation: table state is lost entirely. No partial retention.

## Configuration
- BP_STATS_EN defined: adds outputs stat_branches (out, 32) and stat_mispredicts (out, 32).
  - Both reset to 0.
  - stat_branches increments on every edge with BE=1, non-reserved BS and rst=0.
  - stat_mispredicts increments on the same condition when mispredict=1.
  - Both saturate at 0xFFFF_FFFF.
- BP_STATS_EN undefined: the ports and counters are absent. Predictor behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset, then pred_pc=0x40 → pred_taken=0. BE=1, BS=000, ZERO=1, res_pc=0x40, res_pred=0 → PCS=1, mispredict=1. The cycle after, pred_taken for 0x40 =1 (ctr=2).
- Train 0x40 taken four times → ctr saturates at 3. One not-taken → ctr=2, pred_taken stays 1. Two more not-taken → ctr=0, pred_taken=0. A further not-taken keeps ctr=0.
- Aliasing: train 0x40 to 3, then lookup 0x80 (same idx 0) → pred_taken=1. Lookup 0x44 (idx 1) → pred_taken=0.
- Decode sweep with BE=1 over all BS values and flag combinations → PCS per table above. BS=010/011 → PCS=0, counters unchanged. BE=0 → PCS=0, mispredict=0.
- Same-cycle conflict: pred_pc=res_pc=0x40, ctr=1, taken resolve → pred_taken=0 in that cycle, 1 the next. rst=1 together with a taken resolve → ctr stays 1 after reset.
- With BP_STATS_EN: 5 valid branches, 2 mispredicted, plus 1 reserved BS → stat_branches=5, stat_mispredicts=2. Preload near saturation → both hold at 0xFFFF_FFFF.
